circular_shift_controller: RTL and testbench
============================================

# circular_shift_controller

Sequencer for a 5-bit circular shift-right register. Accepts a start request with a 5-bit pattern and a rotation count, loads the pattern, rotates it right once per enabled cycle until the count is exhausted, then pulses done. It sits between a requesting unit (test stimulus or the next FSM up) and the rotate datapath, so the datapath never has to manage load/shift timing itself.

## Interface
Parameters:
- WIDTH, 5, register width in bits; fixed at 5 for this revision.
- CNT_W, 4, width of the rotation-count field (0..15 rotations).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- clear  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- pattern  input  WIDTH  value to load; captured with start.
- rotations  input  CNT_W  number of right rotations; captured with start.
- hold  input  1  freezes rotation while high (ROTATE state only).
- q  output  WIDTH  current register contents; q[4] is the MSB.
- busy  output  1  high in LOAD, ROTATE and DONE.
- step  output  1  one-cycle pulse on each cycle a rotation is applied.
- done  output  1  one-cycle pulse when the sequence completes.
- remaining  output  CNT_W  rotations still to perform.

## Operation
- Rotation: q_next = {q[0], q[4:1]} (LSB wraps to MSB).
- States: IDLE, LOAD, ROTATE, DONE (2-bit encoding, IDLE = 0).
- IDLE: busy=0. On start=1, capture pattern and rotations and go to LOAD. q is unchanged.
- LOAD: q <= captured pattern; remaining <= captured rotations. Go to ROTATE if rotations != 0, else go to DONE.
- ROTATE with hold=0: rotate q, step=1, remaining <= remaining-1. When remaining == 1, go to DONE.
- ROTATE with hold=1: q, remaining and state are held; step=0.
- DONE: done=1 for exactly this cycle, then go to IDLE. q retains its final value.
- start outside IDLE is ignored; it is neither queued nor latched.
- A start asserted in the DONE cycle is ignored. IDLE is needed to accept a request.
- rotations=15 is valid and gives 15 rotations. Because 15 mod 5 = 0, the final q equals the pattern.
- remaining never underflows. The decrement happens only when remaining >= 1.

## Timing
- Reset (clear=1 at an edge): state=IDLE, q=0, remaining=0, busy=0, step=0, done=0. Clear has priority over every other input, including mid-sequence. No done pulse is produced for an aborted run.
- Latency from start to done: 1 (capture) + 1 (LOAD) + N (unheld ROTATE cycles) + 1 (DONE). For N=0, done rises 2 cycles after the start edge.
- busy rises the cycle after start is sampled. It falls in the cycle after DONE.
- step, done and busy are registered (Moore) outputs, with no combinational path from the inputs.
- Minimum spacing between sequences: done cycle, then 1 IDLE cycle, then a new start.

## Structure
- Shared include file (guarded, same style as the existing flip-flop includes) holding:
  - the state encodings `CSC_IDLE/`CSC_LOAD/`CSC_ROTATE/`CSC_DONE;
  - the WIDTH/CNT_W defaults.
- Sub-module rotate_right_register_5bit:
  - inputs clock, clear, load, load_value[4:0], shift;
  - output q[4:0];
  - load has priority over shift.
- The controller holds the FSM, the capture registers and the down-counter.

## Test plan
- Reset: drive clear for 2 cycles mid-ROTATE (pattern 5'b10110, rotations=4, abort after 2 steps) -> q=0, busy=0, done never pulses, and the FSM returns to IDLE.
- Basic rotate: pattern 5'b00001, rotations=3 -> q goes 00001, 10000, 01000, 00100. Expect 3 step pulses, done 5 cycles after the start edge, and remaining 3→0.
- Zero count: pattern 5'b10101, rotations=0 -> q=10101, no step, and done 2 cycles after start.
- Full wrap: pattern 5'b11010, rotations=5 -> final q=11010. With rotations=15 -> final q=11010 and 15 step pulses.
- Hold: pattern 5'b00011, rotations=2, hold=1 for 3 cycles after the first step -> q stays 10001 during the hold, final q=11000, and done is delayed by exactly 3 cycles.
- Ignored start: pulse start with pattern 5'b11111 during ROTATE and during DONE -> the first sequence result is unaffected and no second sequence begins.

Source files
------------

// File: rtl/circular_shift_controller_pkg.sv
// Shared definitions for the circular shift controller: default widths,
// state encodings and the single-step right-rotate helper.
package circular_shift_controller_pkg;

    localparam int CSC_WIDTH = 5;
    localparam int CSC_CNT_W = 4;

    typedef enum logic [1:0] {
        CSC_IDLE   = 2'd0,
        CSC_LOAD   = 2'd1,
        CSC_ROTATE = 2'd2,
        CSC_DONE   = 2'd3
    } csc_state_e;

    // One right rotation: the LSB wraps around into the MSB.
    function automatic logic [CSC_WIDTH-1:0] rotr1(input logic [CSC_WIDTH-1:0] v);
        return {v[0], v[CSC_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/circular_shift_controller_rotreg.sv
// 5-bit rotate-right register. A load wins over a shift in the same cycle.
module rotate_right_register_5bit
    import circular_shift_controller_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CSC_WIDTH-1:0] load_value,
    input  logic                 shift,
    output logic [CSC_WIDTH-1:0] q
);

    logic [CSC_WIDTH-1:0] q_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= load_value;
        end else if (shift) begin
            q_q <= rotr1(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/circular_shift_controller.sv
// Sequencer that loads a pattern into the rotate register and rotates it right
// once per unheld cycle until the captured count runs out, then pulses done.
module circular_shift_controller
    import circular_shift_controller_pkg::*;
#(
    parameter int WIDTH = CSC_WIDTH,
    parameter int CNT_W = CSC_CNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] rotations,
    input  logic             hold,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    csc_state_e       state_q;
    logic [WIDTH-1:0] pattern_q;
    logic [CNT_W-1:0] rotations_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic             busy_q;
    logic             step_q;
    logic             done_q;
    logic             load_en;
    logic             rotate_en;

    // The remaining != 0 term keeps the counter from ever wrapping below zero.
    assign load_en     = (state_q == CSC_LOAD);
    assign rotate_en   = (state_q == CSC_ROTATE) && !hold && (remaining_q != '0);
    assign remaining_d = remaining_q - CNT_W'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= CSC_IDLE;
            pattern_q   <= '0;
            rotations_q <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                CSC_IDLE: begin
                    if (start) begin
                        pattern_q   <= pattern;
                        rotations_q <= rotations;
                        busy_q      <= 1'b1;
                        state_q     <= CSC_LOAD;
                    end
                end
                CSC_LOAD: begin
                    remaining_q <= rotations_q;
                    if (rotations_q != '0) begin
                        state_q <= CSC_ROTATE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= CSC_DONE;
                    end
                end
                CSC_ROTATE: begin
                    if (rotate_en) begin
                        remaining_q <= remaining_d;
                        step_q      <= 1'b1;
                        if (remaining_q == CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= CSC_DONE;
                        end
                    end
                end
                CSC_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= CSC_IDLE;
                end
                default: state_q <= CSC_IDLE;
            endcase
        end
    end

    rotate_right_register_5bit u_rotreg (
        .clock      (clock),
        .clear      (clear),
        .load       (load_en),
        .load_value (pattern_q),
        .shift      (rotate_en),
        .q          (q)
    );

    assign busy      = busy_q;
    assign step      = step_q;
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_circular_shift_controller.sv
// Bench for circular_shift_controller: a per-sequence timeline model builds the
// expected output of every cycle; a negedge process compares the DUT against it.
module tb_circular_shift_controller;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic [4:0] pattern = '0;
    logic [3:0] rotations = '0;
    logic       hold = 1'b0;
    logic [4:0] q;
    logic       busy;
    logic       step;
    logic       done;
    logic [3:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected vector layout: {q[4:0], busy, step, done, remaining[3:0]}
    logic [11:0] exp_q[$];
    logic [11:0] exp_tr[0:511];

    logic [4:0] m_q   = '0;
    logic [3:0] m_rem = '0;
    logic [4:0] last_final;
    int         last_steps;
    int         last_done_idx;

    circular_shift_controller dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .pattern   (pattern),
        .rotations (rotations),
        .hold      (hold),
        .q         (q),
        .busy      (busy),
        .step      (step),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            logic [11:0] e;
            logic [11:0] a;
            e = exp_q.pop_front();
            a = {q, busy, step, done, remaining};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual q=%b busy=%b step=%b done=%b rem=%0d expected q=%b busy=%b step=%b done=%b rem=%0d",
                         $time, a[11:7], a[6], a[5], a[4], a[3:0], e[11:7], e[6], e[5], e[4], e[3:0]);
            end
        end
    end

    // Cycle 0 is the cycle start is driven; the timeline is derived from the
    // rules: one capture cycle, one load cycle, one cycle per unheld rotation,
    // then the done cycle, then idle.
    task automatic run_seq(input logic [4:0] pat, input logic [3:0] n, input int hold_pct,
                           input int hw_lo, input int hw_hi, input bit inject, input int abort_at);
        logic       h[0:511];
        logic [4:0] cur;
        logic [3:0] rem;
        int         t;
        int         len;
        int         steps;
        bit         aborting;
        for (int i = 0; i < 512; i++)
            h[i] = (i >= hw_lo && i <= hw_hi) || (i < 200 && int'($urandom_range(99, 0)) < hold_pct);
        exp_tr[0] = {m_q, 1'b0, 1'b0, 1'b0, m_rem};
        exp_tr[1] = {m_q, 1'b1, 1'b0, 1'b0, m_rem};
        cur = pat;
        rem = n;
        steps = 0;
        t = 2;
        exp_tr[2] = {pat, 1'b1, 1'b0, (n == 4'd0), n};
        while (rem != 4'd0) begin
            if (!h[t]) begin
                cur = {cur[0], cur[4:1]};
                rem = rem - 4'd1;
                steps++;
                exp_tr[t+1] = {cur, 1'b1, 1'b1, (rem == 4'd0), rem};
            end else begin
                exp_tr[t+1] = {cur, 1'b1, 1'b0, 1'b0, rem};
            end
            t++;
        end
        exp_tr[t+1] = {cur, 1'b0, 1'b0, 1'b0, 4'd0};
        len = t + 1;
        aborting = (abort_at > 0) && (abort_at < t);
        if (aborting) begin
            for (int i = abort_at + 1; i <= abort_at + 3; i++) exp_tr[i] = '0;
            len = abort_at + 3;
            steps = 0;
            for (int i = 1; i <= abort_at; i++) if (exp_tr[i][5]) steps++;
            cur = '0;
        end
        for (int c = 0; c <= len; c++) begin
            @(posedge clock);
            #1;
            clear     = aborting && (c == abort_at || c == abort_at + 1);
            start     = (c == 0) || (inject && !aborting && c >= 1 && c <= t);
            pattern   = (c == 0) ? pat : (inject ? 5'b11111 : 5'($urandom_range(31, 0)));
            rotations = (c == 0) ? n : 4'($urandom_range(15, 0));
            hold      = h[c];
            exp_q.push_back(exp_tr[c]);
        end
        start = 1'b0;
        hold  = 1'b0;
        m_q   = cur;
        m_rem = '0;
        last_final    = cur;
        last_steps    = steps;
        last_done_idx = aborting ? -1 : t;
    endtask

    initial begin
        // Reset state
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_q", 32'(q), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_step", 32'(step), 0);
        check("reset_done", 32'(done), 0);
        check("reset_remaining", 32'(remaining), 0);
        clear = 1'b0;

        // Basic rotate
        run_seq(5'b00001, 4'd3, 0, -1, -1, 1'b0, 0);
        check("basic_tr_q2", 32'(exp_tr[2][11:7]), 32'b00001);
        check("basic_tr_q3", 32'(exp_tr[3][11:7]), 32'b10000);
        check("basic_tr_q4", 32'(exp_tr[4][11:7]), 32'b01000);
        check("basic_tr_q5", 32'(exp_tr[5][11:7]), 32'b00100);
        check("basic_tr_rem2", 32'(exp_tr[2][3:0]), 3);
        check("basic_tr_rem5", 32'(exp_tr[5][3:0]), 0);
        check("basic_steps", 32'(last_steps), 3);
        check("basic_done_idx", 32'(last_done_idx), 5);
        check("basic_dut_q", 32'(q), 32'b00100);

        // Zero count
        run_seq(5'b10101, 4'd0, 0, -1, -1, 1'b0, 0);
        check("zero_steps", 32'(last_steps), 0);
        check("zero_done_idx", 32'(last_done_idx), 2);
        check("zero_dut_q", 32'(q), 32'b10101);

        // Full wrap
        run_seq(5'b11010, 4'd5, 0, -1, -1, 1'b0, 0);
        check("wrap5_dut_q", 32'(q), 32'b11010);
        run_seq(5'b11010, 4'd15, 0, -1, -1, 1'b0, 0);
        check("wrap15_steps", 32'(last_steps), 15);
        check("wrap15_dut_q", 32'(q), 32'b11010);

        // Hold for 3 cycles after the first step
        run_seq(5'b00011, 4'd2, 0, 3, 5, 1'b0, 0);
        check("hold_tr_q3", 32'(exp_tr[3][11:7]), 32'b10001);
        check("hold_tr_q6", 32'(exp_tr[6][11:7]), 32'b10001);
        check("hold_done_idx", 32'(last_done_idx), 7);
        check("hold_dut_q", 32'(q), 32'b11000);

        // Starts during ROTATE and DONE are ignored
        run_seq(5'b00001, 4'd3, 0, -1, -1, 1'b1, 0);
        check("ignored_start_dut_q", 32'(q), 32'b00100);
        check("ignored_start_busy", 32'(busy), 0);

        // Clear mid-rotation
        run_seq(5'b10110, 4'd4, 0, -1, -1, 1'b0, 4);
        check("abort_steps_before", 32'(last_steps), 2);
        check("abort_dut_q", 32'(q), 0);
        check("abort_dut_busy", 32'(busy), 0);

        // Randomized sequences
        for (int k = 0; k < 30; k++) begin
            logic [4:0] p;
            logic [3:0] n;
            logic [9:0] dbl;
            p = 5'($urandom_range(31, 0));
            n = 4'($urandom_range(15, 0));
            run_seq(p, n, int'($urandom_range(40, 0)), -1, -1, bit'($urandom_range(1, 0)), 0);
            dbl = {p, p} >> (n % 5);
            check("rand_model_final", 32'(last_final), 32'(dbl[4:0]));
        end

        @(negedge clock);
        @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
